// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display arbiter slice.
// The optional Owner output is enabled by DISPLAY_ARB_OWNER_EN.
package display_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Returns the index of the set bit; callers guarantee at most one bit is set.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Request/display bundle between the NoC result ports and the display arbiter.
// DISPLAY_ARB_OWNER_EN adds the Owner index signal.
interface display_arbiter_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]                          Req;
  logic [NREQ*display_arb_pkg::DATA_W-1:0]  ReqData;
  logic                                     Hold;
  logic [NREQ-1:0]                          Ack;
  logic [display_arb_pkg::DATA_W-1:0]       DataOut;
  logic                                     DataValid;
  logic                                     Busy;
`ifdef DISPLAY_ARB_OWNER_EN
  logic [$clog2(NREQ)-1:0]                  Owner;

  modport master (
    output Req, ReqData, Hold,
    input  Ack, DataOut, DataValid, Busy, Owner
  );

  modport slave (
    input  Req, ReqData, Hold,
    output Ack, DataOut, DataValid, Busy, Owner
  );
`else
  modport master (
    output Req, ReqData, Hold,
    input  Ack, DataOut, DataValid, Busy
  );

  modport slave (
    input  Req, ReqData, Hold,
    output Ack, DataOut, DataValid, Busy
  );
`endif

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or above
// ptr wins, wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant_onehot,
  output logic                    any_req
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Sum is one bit wider so the wrap test never overflows, even at NREQ=16.
  always_comb begin
    grant_onehot = '0;
    found        = 1'b0;
    pos          = '0;
    idx          = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NREQ)) pos = pos - (PTR_W+1)'(NREQ);
      idx = pos[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant_onehot[idx] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the shared 32-bit result display.
// Define DISPLAY_ARB_OWNER_EN to add the Owner index output.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DWELL_COUNT = 25_000_000
) (
  input  logic             CLOCK_50,
  input  logic             HRESETn,
  display_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (DWELL_COUNT > 1) ? $clog2(DWELL_COUNT) : 1;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [NREQ-1:0]   grant_onehot;
  logic              any_req;
  logic              load;
  logic              cnt_dec;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req          (bus.Req),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .any_req      (any_req)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data = sel_data | (bus.ReqData[i*DATA_W +: DATA_W] & {DATA_W{grant_onehot[i]}});
    end
  end

  assign win_idx = PTR_W'(onehot_to_idx(16'(grant_onehot)));
  assign ptr_nxt = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;

  // Requests are only looked at in IDLE; HOLD just counts down the dwell.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!bus.Hold) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_dec   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr           <= '0;
      bus.DataOut   <= '0;
      bus.DataValid <= 1'b0;
      bus.Ack       <= '0;
      bus.Busy      <= 1'b0;
    end else begin
      bus.Ack  <= '0;
      bus.Busy <= (state_nxt == HOLD);
      if (load) begin
        ptr           <= ptr_nxt;
        bus.DataOut   <= sel_data;
        bus.DataValid <= 1'b1;
        bus.Ack       <= grant_onehot;
      end
    end
  end

  // With a one-cycle dwell the counter never leaves zero.
  generate
    if (DWELL_COUNT == 1) begin : g_cnt_tied
      assign cnt = '0;
    end else begin : g_cnt
      always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn)     cnt <= '0;
        else if (load)    cnt <= CNT_W'(DWELL_COUNT-1);
        else if (cnt_dec) cnt <= cnt - 1'b1;
      end
    end
  endgenerate

`ifdef DISPLAY_ARB_OWNER_EN
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn)  bus.Owner <= '0;
    else if (load) bus.Owner <= win_idx;
  end
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (NREQ=4, DWELL_COUNT=4) against a
// dwell-countdown reference model, with directed scenarios and a random phase.
module tb_display_arbiter;
  import display_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;

  logic CLOCK_50 = 1'b0;
  logic HRESETn;

  always #10 CLOCK_50 = ~CLOCK_50;

  display_arbiter_if #(.NREQ(NREQ)) bus ();

  display_arbiter #(
    .NREQ        (NREQ),
    .DWELL_COUNT (DWELL)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .HRESETn  (HRESETn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] rdata [NREQ];

  // Reference model: idle/holding plus number of busy cycles still owed.
  bit          m_hold;
  int          m_left;
  int          m_ptr;
  int          m_owner;
  logic [31:0] m_data;
  logic        m_valid;
  logic [3:0]  m_ack;

  task automatic modelReset();
    m_hold  = 0;
    m_left  = 0;
    m_ptr   = 0;
    m_owner = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ack   = '0;
  endtask

  task automatic modelEdge();
    int w;
    w     = -1;
    m_ack = '0;
    if (!m_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && bus.Req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        m_data  = rdata[w];
        m_valid = 1'b1;
        m_ack   = 4'(1 << w);
        m_owner = w;
        m_ptr   = (w + 1) % NREQ;
        m_hold  = 1;
        m_left  = DWELL;
      end
    end else if (!bus.Hold) begin
      m_left = m_left - 1;
      if (m_left == 0) m_hold = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("DataOut",   bus.DataOut,        m_data);
    checkOutput("DataValid", 32'(bus.DataValid), 32'(m_valid));
    checkOutput("Ack",       32'(bus.Ack),       32'(m_ack));
    checkOutput("Busy",      32'(bus.Busy),      32'(m_hold));
`ifdef DISPLAY_ARB_OWNER_EN
    checkOutput("Owner",     32'(bus.Owner),     32'(m_owner));
`endif
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic hold);
    bus.Req  = req;
    bus.Hold = hold;
    for (int i = 0; i < NREQ; i++) bus.ReqData[i*32 +: 32] = rdata[i];
  endtask

  // Inputs are set just after an edge; the model consumes them at the next edge.
  task automatic tick();
    if (HRESETn) modelEdge();
    else         modelReset();
    @(posedge CLOCK_50);
    #1;
    checkAll();
  endtask

  initial begin
    logic [3:0] req;
    int         cd [NREQ];
    int         order [5];
    int         ackCyc [5];
    int         nAck;
    int         busyCnt;
    bit         dataStable;
    bit         ack1Seen;
    int         aidx;

    // Reset with every node requesting.
    for (int i = 0; i < NREQ; i++) rdata[i] = $urandom;
    HRESETn = 1'b0;
    modelReset();
    applyStimulus(4'b1111, 1'b0);
    #1;
    checkAll();
    for (int c = 0; c < 3; c++) tick();
    HRESETn = 1'b1;
    $display("[TB] reset done");

    // Single request from node 2.
    rdata[2] = 32'hDEADBEEF;
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("single_ack", 32'(bus.Ack), 32'h4);
    checkOutput("single_data", bus.DataOut, 32'hDEADBEEF);
    applyStimulus(4'b0000, 1'b0);
    busyCnt = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.Busy) busyCnt++;
    end
    checkOutput("single_busy_len", 32'(busyCnt), 32'd4);

    // Fairness: all nodes request; each drops after its Ack and returns 2 cycles later.
    HRESETn = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    tick();
    HRESETn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rdata[i] = $urandom;
      cd[i]    = 0;
    end
    req  = 4'b1111;
    nAck = 0;
    applyStimulus(req, 1'b0);
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) req[i] = 1'b1;
        end
      end
      if (bus.Ack != '0) begin
        aidx = int'(onehot_to_idx(16'(bus.Ack)));
        req[aidx] = 1'b0;
        cd[aidx]  = 2;
        if (nAck < 5) begin
          order[nAck]  = aidx;
          ackCyc[nAck] = c;
          nAck++;
        end
      end
      applyStimulus(req, 1'b0);
    end
    checkOutput("fair_ack_count", 32'(nAck), 32'd5);
    for (int k = 0; k < nAck; k++) begin
      checkOutput("fair_order", 32'(order[k]), 32'(k % NREQ));
      if (k > 0) checkOutput("fair_spacing", 32'(ackCyc[k] - ackCyc[k-1]), 32'd5);
    end
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 6; c++) tick();

    // Freeze: Hold high for 10 cycles starting in the 2nd HOLD cycle.
    rdata[0] = 32'hC0FFEE00;
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    busyCnt    = bus.Busy ? 1 : 0;
    dataStable = 1'b1;
    tick();
    if (bus.Busy) busyCnt++;
    applyStimulus(4'b1110, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.Busy) busyCnt++;
      if (bus.DataOut !== 32'hC0FFEE00 || bus.Ack !== 4'b0000) dataStable = 1'b0;
    end
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.Busy) busyCnt++;
    end
    checkOutput("freeze_busy_len", 32'(busyCnt), 32'd14);
    checkOutput("freeze_stable", 32'(dataStable), 32'd1);

    // Reset in the 3rd HOLD cycle aborts the dwell at once.
    rdata[2] = 32'h12345678;
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_data",  bus.DataOut,        32'h0);
    checkOutput("midreset_valid", 32'(bus.DataValid), 32'h0);
    checkOutput("midreset_busy",  32'(bus.Busy),      32'h0);
    checkOutput("midreset_ack",   32'(bus.Ack),       32'h0);
    tick();
    HRESETn  = 1'b1;
    rdata[3] = 32'hA5A50003;
    applyStimulus(4'b1000, 1'b0);
    tick();
    checkOutput("postreset_ack", 32'(bus.Ack), 32'h8);
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 6; c++) tick();

    // Withdrawal: node 1 requests only while the arbiter is holding.
    rdata[0] = 32'h0000600D;
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b0);
    ack1Seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.Ack[1]) ack1Seen = 1'b1;
      if (c == 1) applyStimulus(4'b0000, 1'b0);
    end
    checkOutput("withdraw_no_ack", 32'(ack1Seen), 32'd0);
    checkOutput("withdraw_data", bus.DataOut, 32'h0000600D);

    // Random phase: changing requests, data and occasional Hold.
    req = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) rdata[i] = $urandom;
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      req = req & ~bus.Ack;
      applyStimulus(req, ($urandom_range(0, 5) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
